// File: rtl/bakery_bw_mutex_pkg.sv
// ============================================================================
// bakery_pkg : shared location encoding and mode constants for the bakery model
// Rev 1.0
// ============================================================================
`default_nettype none

package bakery_pkg;

   typedef enum logic [3:0] {
      L1  = 4'd1,
      L2  = 4'd2,
      L3  = 4'd3,
      L4  = 4'd4,
      L5  = 4'd5,
      L6  = 4'd6,
      L7  = 4'd7,
      L8  = 4'd8,
      L9  = 4'd9,
      L10 = 4'd10,
      L11 = 4'd11
   } loc_t;

   localparam int MODE_CLASSIC = 0;
   localparam int MODE_BW      = 1;

endpackage

`default_nettype wire

// File: rtl/bakery_bw_mutex_if.sv
// ============================================================================
// bakery_bw_mutex_if : scheduler inputs and observation outputs of the mutex model
// Rev 1.0
// ============================================================================
`default_nettype none

interface bakery_bw_mutex_if #(
   parameter int HIPROC = 1,
   parameter int SELMSB = 1
);
   logic [SELMSB:0] select;
   logic            pause;
   logic [HIPROC:0] in_cs;
   logic [3:0]      sel_pc;
   logic            color;
   logic            mutex_err;
   logic            tk_ovf;

   modport master (
      output select, pause,
      input  in_cs, sel_pc, color, mutex_err, tk_ovf
   );

   modport slave (
      input  select, pause,
      output in_cs, sel_pc, color, mutex_err, tk_ovf
   );
endinterface

`default_nettype wire

// File: rtl/bakery_bw_mutex_ticket_max.sv
// ============================================================================
// bakery_ticket_max : combinational maximum over the enabled subset of tickets
// Rev 1.0
// ============================================================================
`default_nettype none

module bakery_ticket_max #(
   parameter int HIPROC = 1,
   parameter int TKMSB  = 2
) (
   input  logic [HIPROC:0][TKMSB:0] i_ticket,
   input  logic [HIPROC:0]          i_enable,
   output logic [TKMSB:0]           o_max
);

   logic [TKMSB:0] w_max;

   always_comb begin
      w_max = '0;
      for (int i = 0; i <= HIPROC; i++) begin
         if (i_enable[i] && (i_ticket[i] > w_max)) begin
            w_max = i_ticket[i];
         end
      end
   end

   assign o_max = w_max;

endmodule

`default_nettype wire

// File: rtl/bakery_bw_mutex.sv
// ============================================================================
// bakery_bw_mutex : N-process Lamport / Black-White bakery, one process step per clock
// Rev 1.0
// ============================================================================
`default_nettype none

module bakery_bw_mutex
   import bakery_pkg::*;
#(
   parameter int HIPROC = 1,
   parameter int SELMSB = 1,
   parameter int TKMSB  = 2,
   parameter int MODE   = 1
) (
   input  logic               clock,
   input  logic               reset_n,
   bakery_bw_mutex_if.slave   bus
);

   typedef logic [SELMSB:0] sel_t;
   localparam sel_t c_hi_sel = sel_t'(HIPROC);

   loc_t                    r_pc [0:HIPROC];
   sel_t                    r_j  [0:HIPROC];
   logic [HIPROC:0][TKMSB:0] r_ticket;
   logic [HIPROC:0]         r_choosing;
   logic [HIPROC:0]         r_mycol;
   logic [HIPROC:0]         r_in_cs;
   logic                    r_color;
   sel_t                    r_sel;
   logic                    r_mutex_err;
   logic                    r_tk_ovf;

   sel_t            w_s;
   sel_t            w_k;
   loc_t            w_pc_s;
   loc_t            w_pc_nxt;
   loc_t            w_sel_pc;
   logic [TKMSB:0]  w_tk_s;
   logic [TKMSB:0]  w_tk_k;
   logic            w_col_s;
   logic            w_col_k;
   logic            w_ch_k;
   logic            w_blocked;
   logic [HIPROC:0] w_en;
   logic [HIPROC:0] w_cs_nxt;
   logic [TKMSB:0]  w_max;
   logic [TKMSB+1:0] w_inc;

   assign w_s = (bus.select > c_hi_sel) ? '0 : bus.select;

   // Gather the stepping process's view of itself and of its current peer k = j[s].
   always_comb begin
      w_pc_s  = L1;
      w_tk_s  = '0;
      w_col_s = 1'b0;
      w_k     = '0;
      w_tk_k  = '0;
      w_col_k = 1'b0;
      w_ch_k  = 1'b0;
      for (int p = 0; p <= HIPROC; p++) begin
         if (w_s == sel_t'(p)) begin
            w_pc_s  = r_pc[p];
            w_tk_s  = r_ticket[p];
            w_col_s = r_mycol[p];
            w_k     = r_j[p];
         end
      end
      for (int p = 0; p <= HIPROC; p++) begin
         if (w_k == sel_t'(p)) begin
            w_tk_k  = r_ticket[p];
            w_col_k = r_mycol[p];
            w_ch_k  = r_choosing[p];
         end
      end
   end

   always_comb begin
      if ((MODE == MODE_BW) && (w_col_k != w_col_s)) begin
         w_blocked = (w_tk_k != '0) && (w_col_s == r_color);
      end else begin
         w_blocked = (w_tk_k != '0) &&
                     ((w_tk_k < w_tk_s) || ((w_tk_k == w_tk_s) && (w_k < w_s)));
      end
   end

   assign w_en  = (MODE == MODE_BW) ? ~(r_mycol ^ {(HIPROC+1){r_color}}) : '1;
   assign w_inc = {1'b0, w_max} + {{(TKMSB+1){1'b0}}, 1'b1};

   bakery_ticket_max #(
      .HIPROC (HIPROC),
      .TKMSB  (TKMSB)
   ) u_ticket_max (
      .i_ticket (r_ticket),
      .i_enable (w_en),
      .o_max    (w_max)
   );

   always_comb begin
      case (w_pc_s)
         L1:      w_pc_nxt = L2;
         L2:      w_pc_nxt = L3;
         L3:      w_pc_nxt = L4;
         L4:      w_pc_nxt = L5;
         L5:      w_pc_nxt = (w_k <= c_hi_sel) ? L6 : L9;
         L6:      w_pc_nxt = w_ch_k ? L6 : L7;
         L7:      w_pc_nxt = w_blocked ? L7 : L8;
         L8:      w_pc_nxt = L5;
         L9:      w_pc_nxt = bus.pause ? L9 : L10;
         L10:     w_pc_nxt = L11;
         L11:     w_pc_nxt = bus.pause ? L11 : L1;
         default: w_pc_nxt = L1;
      endcase
   end

   always_comb begin
      w_cs_nxt = '0;
      for (int p = 0; p <= HIPROC; p++) begin
         w_cs_nxt[p] = (w_s == sel_t'(p)) ? (w_pc_nxt == L9) : (r_pc[p] == L9);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p <= HIPROC; p++) begin
            r_pc[p] <= L1;
            r_j[p]  <= '0;
         end
         r_ticket    <= '0;
         r_choosing  <= '0;
         r_mycol     <= '0;
         r_in_cs     <= '0;
         r_color     <= 1'b0;
         r_sel       <= '0;
         r_mutex_err <= 1'b0;
         r_tk_ovf    <= 1'b0;
      end else begin
         r_sel       <= w_s;
         r_in_cs     <= w_cs_nxt;
         r_mutex_err <= r_mutex_err | ($countones(w_cs_nxt) > 1);
         if ((w_pc_s == L2) && w_inc[TKMSB+1]) begin
            r_tk_ovf <= 1'b1;
         end
         for (int p = 0; p <= HIPROC; p++) begin
            if (w_s == sel_t'(p)) begin
               r_pc[p] <= w_pc_nxt;
               case (w_pc_s)
                  L1: r_choosing[p] <= 1'b1;
                  L2: begin
                     r_ticket[p] <= w_inc[TKMSB:0];
                     if (MODE == MODE_BW) r_mycol[p] <= r_color;
                  end
                  L3: r_choosing[p] <= 1'b0;
                  L4: r_j[p] <= '0;
                  L8: r_j[p] <= r_j[p] + sel_t'(1);
                  L10: begin
                     r_ticket[p] <= '0;
                     // Hand priority to the other colour on exit.
                     if (MODE == MODE_BW) r_color <= ~r_mycol[p];
                  end
                  default: ;
               endcase
            end
         end
      end
   end

   always_comb begin
      w_sel_pc = L1;
      for (int p = 0; p <= HIPROC; p++) begin
         if (r_sel == sel_t'(p)) w_sel_pc = r_pc[p];
      end
   end

   assign bus.in_cs     = r_in_cs;
   assign bus.sel_pc    = w_sel_pc;
   assign bus.color     = r_color;
   assign bus.mutex_err = r_mutex_err;
   assign bus.tk_ovf    = r_tk_ovf;

endmodule

`default_nettype wire

// File: tb/tb_bakery_bw_mutex.sv
// ============================================================================
// tb_bakery_bw_mutex : three configurations driven in lockstep against a bakery model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bakery_bw_mutex;

   localparam int NI = 3;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   always #5 clock = ~clock;

   bakery_bw_mutex_if #(.HIPROC(1), .SELMSB(1)) bus0 ();
   bakery_bw_mutex_if #(.HIPROC(1), .SELMSB(1)) bus1 ();
   bakery_bw_mutex_if #(.HIPROC(2), .SELMSB(1)) bus2 ();

   bakery_bw_mutex #(.HIPROC(1), .SELMSB(1), .TKMSB(1), .MODE(1)) u_dut0 (
      .clock(clock), .reset_n(reset_n), .bus(bus0));
   bakery_bw_mutex #(.HIPROC(1), .SELMSB(1), .TKMSB(0), .MODE(0)) u_dut1 (
      .clock(clock), .reset_n(reset_n), .bus(bus1));
   bakery_bw_mutex #(.HIPROC(2), .SELMSB(1), .TKMSB(2), .MODE(1)) u_dut2 (
      .clock(clock), .reset_n(reset_n), .bus(bus2));

   int cfg_hi [NI] = '{1, 1, 2};
   int cfg_bw [NI] = '{1, 0, 1};
   int cfg_tw [NI] = '{2, 1, 3};

   int m_pc  [NI][3];
   int m_tk  [NI][3];
   int m_j   [NI][3];
   bit m_ch  [NI][3];
   bit m_col [NI][3];
   bit m_color [NI];
   bit m_ovf   [NI];
   bit m_err   [NI];
   int m_last  [NI];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic model_reset();
      for (int n = 0; n < NI; n++) begin
         for (int p = 0; p < 3; p++) begin
            m_pc[n][p] = 1; m_tk[n][p] = 0; m_j[n][p] = 0;
            m_ch[n][p] = 1'b0; m_col[n][p] = 1'b0;
         end
         m_color[n] = 1'b0; m_ovf[n] = 1'b0; m_err[n] = 1'b0; m_last[n] = 0;
      end
   endtask

   // Does process me have to yield to process o right now?
   function automatic bit waits_for(int n, int me, int o);
      if (m_tk[n][o] == 0) return 1'b0;
      if (!cfg_bw[n] || (m_col[n][me] == m_col[n][o]))
         return (m_tk[n][o] * 16 + o) < (m_tk[n][me] * 16 + me);
      return m_col[n][me] == m_color[n];
   endfunction

   task automatic model_step(input int n, input int sel, input bit pz);
      int s, mx, hi, md;
      hi = cfg_hi[n];
      md = 1 << cfg_tw[n];
      s  = (sel > hi) ? 0 : sel;
      case (m_pc[n][s])
         1: begin m_ch[n][s] = 1'b1; m_pc[n][s] = 2; end
         2: begin
            mx = 0;
            for (int i = 0; i <= hi; i++)
               if ((!cfg_bw[n] || m_col[n][i] == m_color[n]) && m_tk[n][i] > mx) mx = m_tk[n][i];
            if (cfg_bw[n] != 0) m_col[n][s] = m_color[n];
            if (mx + 1 == md) m_ovf[n] = 1'b1;
            m_tk[n][s] = (mx + 1) % md;
            m_pc[n][s] = 3;
         end
         3: begin m_ch[n][s] = 1'b0; m_pc[n][s] = 4; end
         4: begin m_j[n][s] = 0; m_pc[n][s] = 5; end
         5: m_pc[n][s] = (m_j[n][s] <= hi) ? 6 : 9;
         6: m_pc[n][s] = m_ch[n][m_j[n][s]] ? 6 : 7;
         7: m_pc[n][s] = waits_for(n, s, m_j[n][s]) ? 7 : 8;
         8: begin m_j[n][s] = m_j[n][s] + 1; m_pc[n][s] = 5; end
         9: m_pc[n][s] = pz ? 9 : 10;
         10: begin
            m_tk[n][s] = 0;
            if (cfg_bw[n] != 0) m_color[n] = !m_col[n][s];
            m_pc[n][s] = 11;
         end
         default: m_pc[n][s] = pz ? 11 : 1;
      endcase
      mx = 0;
      for (int i = 0; i <= hi; i++) if (m_pc[n][i] == 9) mx++;
      if (mx > 1) m_err[n] = 1'b1;
      m_last[n] = s;
   endtask

   // {ovf, err, color, sel_pc[3:0], in_cs[2:0], ticket2, ticket1, ticket0 (4 bits each)}
   function automatic logic [21:0] exp_word(int n);
      logic [21:0] w;
      w = '0;
      for (int p = 0; p <= cfg_hi[n]; p++) begin
         w[p*4 +: 4] = 4'(m_tk[n][p]);
         w[12+p]     = (m_pc[n][p] == 9);
      end
      w[18:15] = 4'(m_pc[n][m_last[n]]);
      w[19] = m_color[n];
      w[20] = m_err[n];
      w[21] = m_ovf[n];
      return w;
   endfunction

   function automatic logic [21:0] act_word(int n);
      logic [21:0] w;
      case (n)
         0: w = {bus0.tk_ovf, bus0.mutex_err, bus0.color, bus0.sel_pc, 1'b0, bus0.in_cs,
                 4'd0, 4'(u_dut0.r_ticket[1]), 4'(u_dut0.r_ticket[0])};
         1: w = {bus1.tk_ovf, bus1.mutex_err, bus1.color, bus1.sel_pc, 1'b0, bus1.in_cs,
                 4'd0, 4'(u_dut1.r_ticket[1]), 4'(u_dut1.r_ticket[0])};
         default: w = {bus2.tk_ovf, bus2.mutex_err, bus2.color, bus2.sel_pc, bus2.in_cs,
                 4'(u_dut2.r_ticket[2]), 4'(u_dut2.r_ticket[1]), 4'(u_dut2.r_ticket[0])};
      endcase
      return w;
   endfunction

   task automatic tick(input int sel, input bit pz);
      bus0.select = 2'(sel); bus1.select = 2'(sel); bus2.select = 2'(sel);
      bus0.pause = pz; bus1.pause = pz; bus2.pause = pz;
      @(posedge clock);
      for (int n = 0; n < NI; n++) model_step(n, sel, pz);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clock);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      bus0.select = '0; bus1.select = '0; bus2.select = '0;
      bus0.pause = 1'b0; bus1.pause = 1'b0; bus2.pause = 1'b0;
      do_reset();
      for (int n = 0; n < NI; n++) begin
         n_cmp++;
         if (act_word(n) !== 22'h008000) begin
            n_bad++;
            $display("FAIL reset[%0d]: got %h want %h", n, act_word(n), 22'h008000);
         end
      end
   endtask

   task automatic test_solo();
      do_reset();
      for (int c = 1; c <= 15; c++) begin
         tick(0, 1'b0);
         for (int n = 0; n < NI; n++) begin
            n_cmp++;
            if (act_word(n) !== exp_word(n)) begin
               n_bad++;
               $display("FAIL solo[%0d] clk %0d: got %h want %h", n, c, act_word(n), exp_word(n));
            end
         end
         if (c == 13) begin
            n_cmp += 2;
            if (bus0.in_cs !== 2'b01 || u_dut0.r_ticket[0] !== 2'd1) begin
               n_bad++;
               $display("FAIL solo_entry: in_cs %b ticket %0d want 01 / 1", bus0.in_cs, u_dut0.r_ticket[0]);
            end
            if (bus1.in_cs !== 2'b01) begin
               n_bad++;
               $display("FAIL solo_entry_classic: in_cs %b want 01", bus1.in_cs);
            end
         end
         if (c == 15) begin
            n_cmp += 2;
            if (u_dut0.r_ticket[0] !== 2'd0 || bus0.color !== 1'b1) begin
               n_bad++;
               $display("FAIL solo_exit: ticket %0d color %b want 0 / 1", u_dut0.r_ticket[0], bus0.color);
            end
            if (bus1.color !== 1'b0) begin
               n_bad++;
               $display("FAIL solo_color_classic: color %b want 0", bus1.color);
            end
         end
      end
   endtask

   task automatic test_alternate();
      int t0, t1;
      t0 = 0; t1 = 0;
      do_reset();
      for (int c = 1; c <= 80; c++) begin
         tick((c - 1) % 2, 1'b0);
         for (int n = 0; n < NI; n++) begin
            n_cmp++;
            if (act_word(n) !== exp_word(n)) begin
               n_bad++;
               $display("FAIL alternate[%0d] clk %0d: got %h want %h", n, c, act_word(n), exp_word(n));
            end
         end
         if (t0 == 0 && bus0.in_cs[0]) t0 = c;
         if (t1 == 0 && bus0.in_cs[1]) t1 = c;
      end
      n_cmp += 3;
      if (!(t0 != 0 && t1 > t0)) begin
         n_bad++;
         $display("FAIL alternate_order: p0 entered clk %0d p1 clk %0d, want p0 first", t0, t1);
      end
      if (bus0.mutex_err !== 1'b0) begin
         n_bad++;
         $display("FAIL alternate_mutex: mutex_err %b want 0", bus0.mutex_err);
      end
      if (bus1.tk_ovf !== 1'b1) begin
         n_bad++;
         $display("FAIL alternate_wrap: tk_ovf %b want 1", bus1.tk_ovf);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      for (int c = 1; c <= 400; c++) begin
         if (c <= 4) tick((c - 1) % 2, 1'b0);
         else tick(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         for (int n = 0; n < NI; n++) begin
            n_cmp++;
            if (act_word(n) !== exp_word(n)) begin
               n_bad++;
               $display("FAIL overflow[%0d] clk %0d: got %h want %h", n, c, act_word(n), exp_word(n));
            end
         end
         if (c >= 4) begin
            n_cmp++;
            if (bus1.tk_ovf !== 1'b1 || bus0.tk_ovf !== 1'b0 || bus0.mutex_err !== 1'b0) begin
               n_bad++;
               $display("FAIL overflow_flags clk %0d: ovf1 %b ovf0 %b err0 %b want 1 0 0",
                        c, bus1.tk_ovf, bus0.tk_ovf, bus0.mutex_err);
            end
         end
      end
   endtask

   task automatic test_select_high();
      do_reset();
      for (int c = 1; c <= 20; c++) begin
         tick(3, 1'($urandom_range(0, 1)));
         for (int n = 0; n < NI; n++) begin
            n_cmp++;
            if (act_word(n) !== exp_word(n)) begin
               n_bad++;
               $display("FAIL select_high[%0d] clk %0d: got %h want %h", n, c, act_word(n), exp_word(n));
            end
         end
         n_cmp++;
         if (bus0.sel_pc !== 4'(m_pc[0][0])) begin
            n_bad++;
            $display("FAIL select_high_pc clk %0d: sel_pc %0d want %0d", c, bus0.sel_pc, m_pc[0][0]);
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      for (int c = 1; c <= 20; c++) tick(0, 1'b1);
      n_cmp++;
      if (bus0.in_cs !== 2'b01) begin
         n_bad++;
         $display("FAIL async_pre: in_cs %b want 01", bus0.in_cs);
      end
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      for (int n = 0; n < NI; n++) begin
         n_cmp++;
         if (act_word(n) !== 22'h008000) begin
            n_bad++;
            $display("FAIL async_reset[%0d]: got %h want %h", n, act_word(n), 22'h008000);
         end
      end
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         tick(0, 1'b0);
         for (int n = 0; n < NI; n++) begin
            n_cmp++;
            if (act_word(n) !== exp_word(n)) begin
               n_bad++;
               $display("FAIL restart[%0d] clk %0d: got %h want %h", n, c, act_word(n), exp_word(n));
            end
         end
      end
      n_cmp++;
      if (bus0.in_cs !== 2'b01) begin
         n_bad++;
         $display("FAIL restart_entry: in_cs %b want 01", bus0.in_cs);
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 1; c <= 10000; c++) begin
         tick(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         for (int n = 0; n < NI; n++) begin
            n_cmp++;
            if (act_word(n) !== exp_word(n)) begin
               n_bad++;
               $display("FAIL random[%0d] clk %0d: got %h want %h", n, c, act_word(n), exp_word(n));
            end
         end
         n_cmp++;
         if (bus2.mutex_err !== 1'b0 || bus0.mutex_err !== 1'b0) begin
            n_bad++;
            $display("FAIL random_mutex clk %0d: err2 %b err0 %b want 0 0", c, bus2.mutex_err, bus0.mutex_err);
         end
         for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (u_dut2.r_ticket[i] > 3'd3) begin
               n_bad++;
               $display("FAIL random_bound clk %0d: ticket[%0d] %0d want <= 3", c, i, u_dut2.r_ticket[i]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_solo();
      test_alternate();
      test_overflow();
      test_select_high();
      test_async_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
